// File: rtl/pipeline_mem_arbiter_if.sv
// Datapath/RAM bundle for the single-port memory arbiter.
// slave: arbiter side; master: pipeline + RAM side.
interface pipeline_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ramload, ram_ready,
    output ihit, dhit, iload, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ramload, ram_ready,
    input  ihit, dhit, iload, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Serializes fetch and MEM-stage requests onto one RAM port.
// Ports: CLK, nRST (async low), bus (slave: requests, hits,
// loads, registered RAM strobes/addr/data, ramload, ram_ready).
// ARB_STARVE_GUARD_EN: fetch wins once after MAX_DSTREAK
// consecutive data grants made while a fetch was waiting.
module pipeline_mem_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input logic                   CLK,
  input logic                   nRST,
  pipeline_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DDONE = 3'd3,
    IDONE = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        abort_q, abort_d;
  logic        ihit, dhit;

  logic idle;
  logic dreq;
  logic fetch_turn;
  logic take_d;
  logic take_i;
  logic flush;

  assign idle = (state_q == IDLE);
  assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] streak_q, streak_d;

  assign fetch_turn = bus.iREN &
                      (streak_q == 3'(MAX_DSTREAK));

  always_comb begin
    streak_d = streak_q;
    if (take_i || (idle && !bus.iREN))
      streak_d = 3'd0;
    else if (take_d && bus.iREN && streak_q != 3'd7)
      streak_d = streak_q + 3'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) streak_q <= 3'd0;
    else       streak_q <= streak_d;
  end
`else
  logic unused_max_dstreak;
  assign unused_max_dstreak = (MAX_DSTREAK == 0);
  assign fetch_turn = 1'b0;
`endif

  assign take_d = idle & dreq & ~fetch_turn;
  assign take_i = idle & bus.iREN & (~dreq | fetch_turn);

  // A fetch flushed at any point of IACC stays flushed even
  // if iREN comes back before the RAM finishes.
  assign flush = abort_q | ~bus.iREN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          take_d:  state_d = DACC;
          take_i:  state_d = IACC;
          default: state_d = IDLE;
        endcase
      end
      DACC:
        if (bus.ram_ready) state_d = DDONE;
      IACC:
        if (bus.ram_ready) state_d = flush ? IDLE : IDONE;
      DDONE:   state_d = IDLE;
      IDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    abort_d = 1'b0;
    ihit    = 1'b0;
    dhit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_d) begin
          // Write wins when both data strobes are high.
          ren_d  = ~bus.dWEN;
          wen_d  = bus.dWEN;
          addr_d = bus.daddr;
          if (bus.dWEN) store_d = bus.dstore;
        end else if (take_i) begin
          ren_d  = 1'b1;
          wen_d  = 1'b0;
          addr_d = bus.iaddr;
        end
      end
      DACC: begin
        if (bus.ram_ready) begin
          ren_d = 1'b0;
          wen_d = 1'b0;
          if (ren_q) dload_d = bus.ramload;
        end
      end
      IACC: begin
        abort_d = flush;
        if (bus.ram_ready) begin
          ren_d   = 1'b0;
          abort_d = 1'b0;
          if (!flush) iload_d = bus.ramload;
        end
      end
      DDONE:   dhit = 1'b1;
      IDONE:   ihit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      abort_q <= 1'b0;
    end else begin
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      abort_q <= abort_d;
    end
  end

  assign bus.ihit     = ihit;
  assign bus.dhit     = dhit;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter.
// Steps are #1 after the rising edge; checks use assertions.
module tb_pipeline_mem_arbiter;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  pipeline_mem_arbiter_if bus ();

  pipeline_mem_arbiter #(
    .MAX_DSTREAK(4)
  ) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ins();
    bus.iREN      = 1'b0;
    bus.iaddr     = '0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.ramload   = '0;
    bus.ram_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic        exp_i;
    checks = 0;
    errors = 0;
    idle_ins();
    nrst = 1'b0;
    #1;
    chk("rst_ihit", 32'(bus.ihit), 0);
    chk("rst_dhit", 32'(bus.dhit), 0);
    chk("rst_ren", 32'(bus.ramREN), 0);
    chk("rst_wen", 32'(bus.ramWEN), 0);
    chk("rst_iload", bus.iload, 0);
    chk("rst_addr", bus.ramaddr, 0);
    tick();
    nrst = 1'b1;
    tick();

    // single fetch: strobe cycle 1, ready cycle 3, hit cycle 4
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    chk("f_ren_c1", 32'(bus.ramREN), 1);
    chk("f_addr_c1", bus.ramaddr, 32'h40);
    chk("f_ihit_c1", 32'(bus.ihit), 0);
    tick();
    chk("f_ren_c2", 32'(bus.ramREN), 1);
    tick();
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h8C220004;
    chk("f_ihit_c3", 32'(bus.ihit), 0);
    tick();
    chk("f_ihit_c4", 32'(bus.ihit), 1);
    chk("f_iload", bus.iload, 32'h8C220004);
    chk("f_ren_c4", 32'(bus.ramREN), 0);
    bus.ram_ready = 1'b0;
    bus.iREN      = 1'b0;
    tick();
    chk("f_ihit_c5", 32'(bus.ihit), 0);

    // collision: data first, then the fetch
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h80;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    tick();
    chk("c_ren_d", 32'(bus.ramREN), 1);
    chk("c_addr_d", bus.ramaddr, 32'h100);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h11112222;
    tick();
    chk("c_dhit", 32'(bus.dhit), 1);
    chk("c_ihit0", 32'(bus.ihit), 0);
    chk("c_dload", bus.dload, 32'h11112222);
    chk("c_ren_off", 32'(bus.ramREN), 0);
    bus.ram_ready = 1'b0;
    bus.dREN      = 1'b0;
    tick();
    chk("c_idle_ren", 32'(bus.ramREN), 0);
    chk("c_idle_dhit", 32'(bus.dhit), 0);
    tick();
    chk("c_ren_i", 32'(bus.ramREN), 1);
    chk("c_addr_i", bus.ramaddr, 32'h80);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h33334444;
    tick();
    chk("c_ihit", 32'(bus.ihit), 1);
    chk("c_dhit0", 32'(bus.dhit), 0);
    chk("c_iload", bus.iload, 32'h33334444);
    bus.ram_ready = 1'b0;
    bus.iREN      = 1'b0;
    tick();

    // write precedence
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h200;
    bus.dstore = 32'hDEADBEEF;
    tick();
    chk("w_wen", 32'(bus.ramWEN), 1);
    chk("w_ren", 32'(bus.ramREN), 0);
    chk("w_addr", bus.ramaddr, 32'h200);
    chk("w_store", bus.ramstore, 32'hDEADBEEF);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'hBAD0BAD0;
    tick();
    chk("w_dhit", 32'(bus.dhit), 1);
    chk("w_dload", bus.dload, 32'h11112222);
    chk("w_wen_off", 32'(bus.ramWEN), 0);
    bus.ram_ready = 1'b0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    tick();

    // flush abort
    bus.iREN  = 1'b1;
    bus.iaddr = 32'hC0;
    tick();
    tick();
    bus.iREN = 1'b0;
    tick();
    chk("a_ren_held", 32'(bus.ramREN), 1);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h55555555;
    tick();
    chk("a_ihit", 32'(bus.ihit), 0);
    chk("a_ren_off", 32'(bus.ramREN), 0);
    chk("a_iload", bus.iload, 32'h33334444);
    bus.ram_ready = 1'b0;
    bus.dREN      = 1'b1;
    bus.daddr     = 32'h300;
    tick();
    chk("a_idle_grant", 32'(bus.ramREN), 1);
    chk("a_idle_addr", bus.ramaddr, 32'h300);

    // reset during DACC
    nrst = 1'b0;
    #1;
    chk("r_ren", 32'(bus.ramREN), 0);
    chk("r_addr", bus.ramaddr, 0);
    chk("r_store", bus.ramstore, 0);
    chk("r_dload", bus.dload, 0);
    chk("r_iload", bus.iload, 0);
    bus.dREN = 1'b0;
    tick();
    nrst = 1'b1;
    bus.ram_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("r_no_ihit", 32'(bus.ihit), 0);
      chk("r_no_dhit", 32'(bus.dhit), 0);
      chk("r_no_ren", 32'(bus.ramREN), 0);
    end
    bus.ram_ready = 1'b0;

    // both requests held: grant order
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h400;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h500;
    for (int g = 0; g < 6; g++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (g == 4);
`else
      exp_i = 1'b0;
`endif
      exp_addr = exp_i ? 32'h400 : 32'h500;
      tick();
      chk("s_ren", 32'(bus.ramREN), 1);
      chk("s_addr", bus.ramaddr, exp_addr);
      bus.ram_ready = 1'b1;
      bus.ramload   = 32'h600 + 32'(g);
      tick();
      chk("s_ihit", 32'(bus.ihit), 32'(exp_i));
      chk("s_dhit", 32'(bus.dhit), 32'(!exp_i));
      bus.ram_ready = 1'b0;
      tick();
      chk("s_gap", 32'(bus.ramREN), 0);
    end
    idle_ins();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
